seg7_scan3: RTL and testbench
=============================

Name: seg7_scan3

Overview:
- Downstream consumer of the vending datapath's 8-bit-to-3-digit BCD converter.
- Latches the hundreds/tens/ones BCD digits and time-multiplexes them onto a 4-anode common-anode seven-segment display.
- Provides a ghost-suppression gap between digits and a frame-synchronous update, so a displayed frame never mixes old and new digits.
- Sits between the credit/price BCD conversion and the board display pins.

Parameters:
- REFRESH_DIV, 50000, CLK cycles per digit slot (≥ 2); the frame is 4 slots.
- GHOST_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- LOAD  in  1  single-cycle strobe; capture HUND_IN/TEN_IN/ONE_IN/DP_SEL.
- HUND_IN  in  4  hundreds BCD digit.
- TEN_IN  in  4  tens BCD digit.
- ONE_IN  in  4  ones BCD digit.
- DP_SEL  in  2  decimal point position: 0 none, 1 after ONE, 2 after TEN, 3 after HUND.
- AN  out  4  anode enables, active-low; AN[0]=ONE, AN[1]=TEN, AN[2]=HUND, AN[3]=unused slot.
- SEG  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point cathode, active-low.
- FRAME_UPD  out  1  one-cycle pulse when pending digits move into the active set.

Behaviour:
- Clock and reset: one clock domain, CLK. RESET_N is asynchronous active-low.
- Reset values:
  - Prescaler = 0, slot = 0.
  - Active and pending digit registers = 0; pending-valid = 0.
  - AN = 4'b1111, SEG = 7'b1111111, DP = 1, FRAME_UPD = 0.
  - Reset mid-frame or mid-slot forces this state immediately; scanning restarts at slot 0 after release.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, slot advances 0→1→2→3→0.
  - The slot 3→0 transition is the frame boundary.
- Capture:
  - LOAD=1 writes all three digits and DP_SEL into the pending registers and sets pending-valid.
  - A repeated LOAD before the boundary overwrites pending; last writer wins.
- Frame update:
  - Applies on the frame-boundary cycle when pending-valid=1.
  - Pending copies into active, pending-valid clears, and FRAME_UPD pulses the same cycle.
- LOAD on the boundary cycle:
  - Active takes the previously pending value, if any.
  - The new value goes into pending and pending-valid stays 1; it displays in the following frame.
  - If nothing was pending, FRAME_UPD stays 0 that boundary.
- Outputs are registered and reflect the prescaler/slot state of the previous cycle (1-cycle latency).
- Within each slot:
  - Prescaler < GHOST_CYCLES: AN = 4'b1111, SEG = all off, DP = 1.
  - Otherwise: the slot's anode is low.
  - Slot 3 keeps every anode high for the whole slot (uniform duty cycle).
- Decode: digits 0–9 use the standard patterns. Digit values 10–15 display a dash (g only: SEG = 7'b0111111).
- DP is low only while the digit selected by the active DP_SEL is lit.
- Width rules: prescaler width = clog2(REFRESH_DIV); slot is 2 bits and wraps naturally.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- With the macro:
  - HUND is blanked when active HUND==0.
  - TEN is blanked when HUND==0 and TEN==0.
  - ONE is never blanked.
  - A digit holding the DP is never blanked.
  - A blanked digit drives SEG all off with its anode still low.
- Without the macro: all three digits are always shown, including leading zeros.

Decomposition:
- Shared include vending_defs.vh holds:
  - the seven-segment pattern constants for 0–9, dash and blank;
  - the slot encodings;
  - the DP_SEL encodings.
- One natural sub-module: bcd_to_seg7, a combinational 4-bit digit to 7-bit active-low pattern with dash for values > 9. It is instantiated once on the muxed active digit.

Test Plan (REFRESH_DIV=4, GHOST_CYCLES=1):
1. Reset release, no LOAD: every slot shows "0". AN sequence per slot is 1111 then 1110, 1111 then 1101, 1111 then 1011, then 1111 for 4 cycles; SEG = 7'b1000000 when lit.
2. LOAD digits 2/5/5, DP_SEL=0, mid-slot 1: display unchanged until the frame boundary. FRAME_UPD pulses once; the next frame shows ONE=5 (7'b0010010), TEN=5, HUND=2 (7'b0100100).
3. Two LOADs in one frame (1/2/3 then 0/4/7): only 0/4/7 is ever displayed, with one FRAME_UPD.
4. LOAD 1/0/0 exactly on the boundary cycle while 0/9/9 is pending: the next frame shows 0/9/9, the following frame shows 1/0/0, and FRAME_UPD fires at both boundaries.
5. LOAD HUND=4'hC, DP_SEL=2: the HUND slot shows 7'b0111111, and DP=0 only during the TEN slot.
6. Assert RESET_N low mid-slot 2: AN=1111 and SEG=all off immediately; after release, scanning restarts at slot 0 showing 0/0/0. With SEG7_LZB_EN defined, 0/0/7 shows only ONE lit with 7'b1111000.

Source files
------------

// File: rtl/seg7_scan3_pkg.sv
// rtl/seg7_scan3_pkg.sv - shared segment patterns, slot and DP_SEL encodings for seg7_scan3
//
// Holds the seven-segment cathode patterns (active-low, bit order {g,f,e,d,c,b,a}),
// the scan-slot encoding, the decimal-point selector encoding, the latched
// display-word layout and a helper mapping a DP selector to its scan slot.
package seg7_scan3_pkg;

    // Active-low cathode patterns, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;
    localparam logic [6:0] SEG_DIGIT_4 = 7'b0011001;
    localparam logic [6:0] SEG_DIGIT_5 = 7'b0010010;
    localparam logic [6:0] SEG_DIGIT_6 = 7'b0000010;
    localparam logic [6:0] SEG_DIGIT_7 = 7'b1111000;
    localparam logic [6:0] SEG_DIGIT_8 = 7'b0000000;
    localparam logic [6:0] SEG_DIGIT_9 = 7'b0010000;
    localparam logic [6:0] SEG_DASH    = 7'b0111111;
    localparam logic [6:0] SEG_BLANK   = 7'b1111111;

    // Scan slots; the index doubles as the anode bit number.
    typedef enum logic [1:0] {
        SLOT_ONE  = 2'd0,
        SLOT_TEN  = 2'd1,
        SLOT_HUND = 2'd2,
        SLOT_IDLE = 2'd3
    } slot_t;

    typedef enum logic [1:0] {
        DP_NONE = 2'd0,
        DP_ONE  = 2'd1,
        DP_TEN  = 2'd2,
        DP_HUND = 2'd3
    } dp_sel_t;

    typedef struct packed {
        logic [3:0] hund;
        logic [3:0] ten;
        logic [3:0] one;
        dp_sel_t    dp_sel;
    } disp_t;

    // Slot whose digit carries the decimal point. "None" maps to the idle
    // slot, which is never lit, so no separate enable is needed.
    function automatic slot_t dp_slot(input dp_sel_t sel);
        case (sel)
            DP_ONE:  return SLOT_ONE;
            DP_TEN:  return SLOT_TEN;
            DP_HUND: return SLOT_HUND;
            default: return SLOT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan3_bcd_to_seg7.sv
// rtl/seg7_scan3_bcd_to_seg7.sv - combinational BCD digit to active-low seven-segment pattern
//
// Ports:
//   digit  in  4  BCD digit; values 10..15 render as a dash
//   seg    out 7  cathodes {g,f,e,d,c,b,a}, active-low
module seg7_scan3_bcd_to_seg7
    import seg7_scan3_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_DIGIT_0;
            4'd1:    seg = SEG_DIGIT_1;
            4'd2:    seg = SEG_DIGIT_2;
            4'd3:    seg = SEG_DIGIT_3;
            4'd4:    seg = SEG_DIGIT_4;
            4'd5:    seg = SEG_DIGIT_5;
            4'd6:    seg = SEG_DIGIT_6;
            4'd7:    seg = SEG_DIGIT_7;
            4'd8:    seg = SEG_DIGIT_8;
            4'd9:    seg = SEG_DIGIT_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan3.sv
// rtl/seg7_scan3.sv - three-digit BCD scanner for a 4-anode common-anode seven-segment display
//
// Latches hundreds/tens/ones digits into a pending set and promotes them to
// the displayed set only at the frame boundary (slot 3 -> 0), so a frame
// never mixes old and new digits. Each slot opens with GHOST_CYCLES of all
// anodes off; slot 3 is a dark slot that keeps the duty cycle uniform.
// Optional macro SEG7_LZB_EN enables leading-zero blanking.
//
// Parameters:
//   REFRESH_DIV   clock cycles per slot (>= 2); a frame is 4 slots
//   GHOST_CYCLES  dark cycles at the start of each slot (< REFRESH_DIV)
// Ports:
//   CLK        in  1  system clock
//   RESET_N    in  1  asynchronous active-low reset
//   LOAD       in  1  capture strobe for HUND_IN/TEN_IN/ONE_IN/DP_SEL
//   HUND_IN    in  4  hundreds digit
//   TEN_IN     in  4  tens digit
//   ONE_IN     in  4  ones digit
//   DP_SEL     in  2  0 none, 1 after ONE, 2 after TEN, 3 after HUND
//   AN         out 4  anodes, active-low; [0]=ONE [1]=TEN [2]=HUND [3]=unused
//   SEG        out 7  cathodes {g,f,e,d,c,b,a}, active-low
//   DP         out 1  decimal point cathode, active-low
//   FRAME_UPD  out 1  pulse when pending digits become active
module seg7_scan3
    import seg7_scan3_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       LOAD,
    input  logic [3:0] HUND_IN,
    input  logic [3:0] TEN_IN,
    input  logic [3:0] ONE_IN,
    input  logic [1:0] DP_SEL,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME_UPD
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GHOST_END  = PW'(GHOST_CYCLES);

    logic [PW-1:0] presc;
    slot_t         slot;
    disp_t         active;
    disp_t         pending;
    logic          pend_valid;

    logic          presc_wrap;
    logic          frame_boundary;
    logic          lit;
    logic          blank;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign presc_wrap     = (presc == PRESC_LAST);
    assign frame_boundary = presc_wrap && (slot == SLOT_IDLE);

    // Digit shown in the current slot
    always_comb begin
        cur_digit = active.one;
        case (slot)
            SLOT_ONE:  cur_digit = active.one;
            SLOT_TEN:  cur_digit = active.ten;
            SLOT_HUND: cur_digit = active.hund;
            default:   cur_digit = active.one;
        endcase
    end

    seg7_scan3_bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // A blanked digit keeps its anode on and just darkens the cathodes.
    always_comb begin
        blank = 1'b0;
`ifdef SEG7_LZB_EN
        case (slot)
            SLOT_HUND: blank = (active.hund == 4'd0) && (active.dp_sel != DP_HUND);
            SLOT_TEN:  blank = (active.hund == 4'd0) && (active.ten == 4'd0)
                               && (active.dp_sel != DP_TEN);
            default:   blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    always_comb begin
        an_next  = 4'b1111;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        lit      = (slot != SLOT_IDLE) && (presc >= GHOST_END);
        if (lit) begin
            an_next[slot] = 1'b0;
            seg_next      = blank ? SEG_BLANK : dec_seg;
            dp_next       = (dp_slot(active.dp_sel) != slot);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc      <= '0;
            slot       <= SLOT_ONE;
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            AN         <= 4'b1111;
            SEG        <= SEG_BLANK;
            DP         <= 1'b1;
            FRAME_UPD  <= 1'b0;
        end else begin
            presc <= presc_wrap ? '0 : presc + PW'(1);
            if (presc_wrap) begin
                slot <= slot_t'(slot + 2'd1);
            end

            // The promotion uses the pending value from before this edge, so a
            // LOAD on the boundary cycle lands in pending for the next frame.
            FRAME_UPD <= frame_boundary && pend_valid;
            if (frame_boundary && pend_valid) begin
                active <= pending;
            end
            if (LOAD) begin
                pending    <= '{hund: HUND_IN, ten: TEN_IN, one: ONE_IN,
                                dp_sel: dp_sel_t'(DP_SEL)};
                pend_valid <= 1'b1;
            end else if (frame_boundary) begin
                pend_valid <= 1'b0;
            end

            AN  <= an_next;
            SEG <= seg_next;
            DP  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan3.sv
// tb/tb_seg7_scan3.sv - self-checking bench for seg7_scan3 with a cycle-count reference model
module tb_seg7_scan3;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       LOAD;
    logic [3:0] HUND_IN;
    logic [3:0] TEN_IN;
    logic [3:0] ONE_IN;
    logic [1:0] DP_SEL;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       FRAME_UPD;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    seg7_scan3 #(.REFRESH_DIV(4), .GHOST_CYCLES(1)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .LOAD      (LOAD),
        .HUND_IN   (HUND_IN),
        .TEN_IN    (TEN_IN),
        .ONE_IN    (ONE_IN),
        .DP_SEL    (DP_SEL),
        .AN        (AN),
        .SEG       (SEG),
        .DP        (DP),
        .FRAME_UPD (FRAME_UPD)
    );

    // Reference model: k counts clock edges since reset release. With 4 cycles
    // per slot and 4 slots per frame, the slot position is plain arithmetic on k.
    int k;
    int act_h, act_t, act_o, act_dp;
    int pnd_h, pnd_t, pnd_o, pnd_dp;
    int pv;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fu;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic model_reset();
        k = 0;
        act_h = 0; act_t = 0; act_o = 0; act_dp = 0;
        pnd_h = 0; pnd_t = 0; pnd_o = 0; pnd_dp = 0;
        pv = 0;
    endtask

    // Drives one cycle from a falling edge to the next, updating the model's
    // expectation for the outputs registered at the intervening rising edge.
    task automatic tick(input logic ld, input int h, input int t, input int o, input int dp);
        int pr, sl, dig;
        bit lit;
        LOAD    = ld;
        HUND_IN = 4'(h);
        TEN_IN  = 4'(t);
        ONE_IN  = 4'(o);
        DP_SEL  = 2'(dp);
        @(posedge CLK);
        pr  = k % 4;
        sl  = (k / 4) % 4;
        lit = (sl != 3) && (pr >= 1);
        dig = (sl == 0) ? act_o : (sl == 1) ? act_t : act_h;
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
        e_dp  = 1'b1;
        if (lit) begin
            e_an[sl] = 1'b0;
            e_seg    = ref_seg(dig);
            if (act_dp == sl + 1) e_dp = 1'b0;
        end
        e_fu = ((k % 16) == 15) && (pv != 0);
        if (e_fu) begin
            act_h = pnd_h; act_t = pnd_t; act_o = pnd_o; act_dp = pnd_dp;
            pv = 0;
        end
        if (ld) begin
            pnd_h = h; pnd_t = t; pnd_o = o; pnd_dp = dp;
            pv = 1;
        end
        k++;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        LOAD = 1'b0; HUND_IN = 4'd0; TEN_IN = 4'd0; ONE_IN = 4'd0; DP_SEL = 2'd0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({AN, SEG, DP, FRAME_UPD} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got AN=%b SEG=%b DP=%b FU=%b want AN=1111 SEG=1111111 DP=1 FU=0",
                     AN, SEG, DP, FRAME_UPD);
        end
        RESET_N = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_frame();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 0, 0, 0, 0);
            checks++;
            if ({AN, SEG, DP, FRAME_UPD} !== {e_an, e_seg, e_dp, e_fu}) begin
                errors++;
                $display("FAIL idle k=%0d got AN=%b SEG=%b DP=%b FU=%b want AN=%b SEG=%b DP=%b FU=%b",
                         k, AN, SEG, DP, FRAME_UPD, e_an, e_seg, e_dp, e_fu);
            end
            if (AN != 4'b1111) begin
                checks++;
                if (SEG !== 7'b1000000) begin
                    errors++;
                    $display("FAIL idle_zero_pattern got SEG=%b want 1000000", SEG);
                end
            end
        end
    endtask

    task automatic test_load_mid_frame();
        int stage = 0;
        int fu_cnt = 0;
        bit ld;
        for (int i = 0; i < 40; i++) begin
            ld = (stage == 0) && ((k % 16) == 6);
            if (ld) stage = 1;
            tick(ld, 2, 5, 5, 0);
            checks++;
            if ({AN, SEG, DP, FRAME_UPD} !== {e_an, e_seg, e_dp, e_fu}) begin
                errors++;
                $display("FAIL load_mid k=%0d got AN=%b SEG=%b DP=%b FU=%b want AN=%b SEG=%b DP=%b FU=%b",
                         k, AN, SEG, DP, FRAME_UPD, e_an, e_seg, e_dp, e_fu);
            end
            if (FRAME_UPD === 1'b1) fu_cnt++;
            if (fu_cnt > 0 && AN == 4'b1110) begin
                checks++;
                if (SEG !== 7'b0010010) begin
                    errors++;
                    $display("FAIL load_mid_one got SEG=%b want 0010010", SEG);
                end
            end
            if (fu_cnt > 0 && AN == 4'b1011) begin
                checks++;
                if (SEG !== 7'b0100100) begin
                    errors++;
                    $display("FAIL load_mid_hund got SEG=%b want 0100100", SEG);
                end
            end
        end
        checks++;
        if (fu_cnt != 1) begin
            errors++;
            $display("FAIL load_mid_pulses got %0d want 1", fu_cnt);
        end
    endtask

    task automatic test_double_load();
        int stage = 0;
        int fu_cnt = 0;
        bit ld;
        int h, t, o;
        for (int i = 0; i < 48; i++) begin
            ld = 1'b0; h = 0; t = 0; o = 0;
            if (stage == 0 && (k % 16) == 2) begin
                ld = 1'b1; h = 1; t = 2; o = 3; stage = 1;
            end else if (stage == 1 && (k % 16) == 9) begin
                ld = 1'b1; h = 0; t = 4; o = 7; stage = 2;
            end
            tick(ld, h, t, o, 0);
            checks++;
            if ({AN, SEG, DP, FRAME_UPD} !== {e_an, e_seg, e_dp, e_fu}) begin
                errors++;
                $display("FAIL double_load k=%0d got AN=%b SEG=%b DP=%b FU=%b want AN=%b SEG=%b DP=%b FU=%b",
                         k, AN, SEG, DP, FRAME_UPD, e_an, e_seg, e_dp, e_fu);
            end
            if (FRAME_UPD === 1'b1) fu_cnt++;
            if (fu_cnt > 0 && AN == 4'b1101) begin
                checks++;
                if (SEG !== 7'b0011001) begin
                    errors++;
                    $display("FAIL double_load_ten got SEG=%b want 0011001", SEG);
                end
            end
        end
        checks++;
        if (fu_cnt != 1) begin
            errors++;
            $display("FAIL double_load_pulses got %0d want 1", fu_cnt);
        end
    endtask

    task automatic test_boundary_load();
        int stage = 0;
        int fu_cnt = 0;
        bit ld;
        int h, t, o;
        for (int i = 0; i < 64; i++) begin
            ld = 1'b0; h = 0; t = 0; o = 0;
            if (stage == 0 && (k % 16) == 3) begin
                ld = 1'b1; h = 0; t = 9; o = 9; stage = 1;
            end else if (stage == 1 && (k % 16) == 15) begin
                ld = 1'b1; h = 1; t = 0; o = 0; stage = 2;
            end
            tick(ld, h, t, o, 0);
            checks++;
            if ({AN, SEG, DP, FRAME_UPD} !== {e_an, e_seg, e_dp, e_fu}) begin
                errors++;
                $display("FAIL boundary_load k=%0d got AN=%b SEG=%b DP=%b FU=%b want AN=%b SEG=%b DP=%b FU=%b",
                         k, AN, SEG, DP, FRAME_UPD, e_an, e_seg, e_dp, e_fu);
            end
            if (FRAME_UPD === 1'b1) fu_cnt++;
            if (fu_cnt == 1 && AN == 4'b1101) begin
                checks++;
                if (SEG !== 7'b0010000) begin
                    errors++;
                    $display("FAIL boundary_first_frame got SEG=%b want 0010000", SEG);
                end
            end
        end
        checks++;
        if (fu_cnt != 2) begin
            errors++;
            $display("FAIL boundary_pulses got %0d want 2", fu_cnt);
        end
    endtask

    task automatic test_dash_dp();
        int stage = 0;
        int fu_cnt = 0;
        bit ld;
        for (int i = 0; i < 48; i++) begin
            ld = (stage == 0) && ((k % 16) == 2);
            if (ld) stage = 1;
            tick(ld, 12, 3, 8, 2);
            checks++;
            if ({AN, SEG, DP, FRAME_UPD} !== {e_an, e_seg, e_dp, e_fu}) begin
                errors++;
                $display("FAIL dash_dp k=%0d got AN=%b SEG=%b DP=%b FU=%b want AN=%b SEG=%b DP=%b FU=%b",
                         k, AN, SEG, DP, FRAME_UPD, e_an, e_seg, e_dp, e_fu);
            end
            if (FRAME_UPD === 1'b1) fu_cnt++;
            if (fu_cnt > 0 && AN == 4'b1011) begin
                checks++;
                if (SEG !== 7'b0111111) begin
                    errors++;
                    $display("FAIL dash_hund got SEG=%b want 0111111", SEG);
                end
            end
            if (fu_cnt > 0) begin
                checks++;
                if (DP !== ((AN == 4'b1101) ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("FAIL dp_ten_only AN=%b got DP=%b", AN, DP);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ld;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            tick(ld, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            checks++;
            if ({AN, SEG, DP, FRAME_UPD} !== {e_an, e_seg, e_dp, e_fu}) begin
                errors++;
                $display("FAIL random k=%0d got AN=%b SEG=%b DP=%b FU=%b want AN=%b SEG=%b DP=%b FU=%b",
                         k, AN, SEG, DP, FRAME_UPD, e_an, e_seg, e_dp, e_fu);
            end
        end
    endtask

    task automatic test_async_reset();
        // Load something visible, let it reach the display, then park mid-slot 2.
        for (int i = 0; i < 64 && !((i > 20) && ((k % 16) == 10)); i++) begin
            tick((k % 16) == 1, 6, 7, 8, 3);
            checks++;
            if ({AN, SEG, DP, FRAME_UPD} !== {e_an, e_seg, e_dp, e_fu}) begin
                errors++;
                $display("FAIL pre_reset k=%0d got AN=%b SEG=%b DP=%b FU=%b want AN=%b SEG=%b DP=%b FU=%b",
                         k, AN, SEG, DP, FRAME_UPD, e_an, e_seg, e_dp, e_fu);
            end
        end
        checks++;
        if (AN !== 4'b1011) begin
            errors++;
            $display("FAIL pre_reset_slot got AN=%b want 1011", AN);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({AN, SEG, DP, FRAME_UPD} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got AN=%b SEG=%b DP=%b FU=%b want AN=1111 SEG=1111111 DP=1 FU=0",
                     AN, SEG, DP, FRAME_UPD);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 0, 0, 0, 0);
            checks++;
            if ({AN, SEG, DP, FRAME_UPD} !== {e_an, e_seg, e_dp, e_fu}) begin
                errors++;
                $display("FAIL post_reset k=%0d got AN=%b SEG=%b DP=%b FU=%b want AN=%b SEG=%b DP=%b FU=%b",
                         k, AN, SEG, DP, FRAME_UPD, e_an, e_seg, e_dp, e_fu);
            end
            if (i == 1) begin
                checks++;
                if ({AN, SEG} !== {4'b1110, 7'b1000000}) begin
                    errors++;
                    $display("FAIL restart_slot0 got AN=%b SEG=%b want AN=1110 SEG=1000000", AN, SEG);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_frame();
        test_load_mid_frame();
        test_double_load();
        test_boundary_load();
        test_dash_dp();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
